// File: rtl/arith_accum_pkg.sv
// Shared definitions for the accumulation stage: FSM encoding and default widths.
package lab_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_N_SAMPLES = 4;
  localparam int DEF_ACC_W     = 24;
  localparam int SUM_W         = 9;
  localparam int PROD_W        = 16;
  localparam int CNT_W         = 8;

endpackage

// File: rtl/arith_accum_sat_add.sv
// Unsigned saturating adder: clamps to all-ones when the add carries out.
module sat_add #(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W:0] full;

  // One extra bit catches the carry; a carry forces the result to all-ones.
  always_comb begin
    full = {1'b0, a} + {1'b0, b};
    ovf  = full[W];
    sum  = full[W] ? '1 : full[W-1:0];
  end

endmodule

// File: rtl/arith_accum.sv
// Burst accumulator: collects N_SAMPLES sum/product pairs into saturating
// totals, then holds them behind a valid/ready output handshake.
module arith_accum
  import lab_defs::*;
#(
  parameter int N_SAMPLES = DEF_N_SAMPLES,
  parameter int ACC_W     = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SUM_W-1:0]  sum_in,
  input  logic [PROD_W-1:0] prod_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_prod,
  output logic [ACC_W-1:0]  acc_sum,
  output logic [CNT_W-1:0]  count,
  output logic              sat,
  output logic              busy
);

  // Count value held just before the final sample of a burst is accepted.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES - 1);

  state_e           state_q;
  logic             in_ready_q, out_valid_q, busy_q, sat_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ACC_W-1:0] prod_q, sum_q;

  logic [ACC_W-1:0] prod_ext, sum_ext, prod_d, sum_d;
  logic             prod_ovf, sum_ovf;

  assign prod_ext = ACC_W'(prod_in);
  assign sum_ext  = ACC_W'(sum_in);

  sat_add #(.W(ACC_W)) u_prod_add (
    .a   (prod_q),
    .b   (prod_ext),
    .sum (prod_d),
    .ovf (prod_ovf)
  );

  sat_add #(.W(ACC_W)) u_sum_add (
    .a   (sum_q),
    .b   (sum_ext),
    .sum (sum_d),
    .ovf (sum_ovf)
  );

  // Burst FSM; handshake flags are registered alongside the state so
  // in_ready never sees in_valid combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sat_q       <= 1'b0;
      cnt_q       <= '0;
      prod_q      <= '0;
      sum_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q    <= ACC;
          in_ready_q <= 1'b1;
          busy_q     <= 1'b1;
          sat_q      <= 1'b0;
          cnt_q      <= '0;
          prod_q     <= '0;
          sum_q      <= '0;
        end
        ACC: if (in_valid) begin
          prod_q <= prod_d;
          sum_q  <= sum_d;
          sat_q  <= sat_q | prod_ovf | sum_ovf;
          cnt_q  <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_q     <= DONE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          // A start arriving with the handoff is deliberately dropped.
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sat       = sat_q;
  assign count     = cnt_q;
  assign acc_prod  = prod_q;
  assign acc_sum   = sum_q;

endmodule

// File: tb/tb_arith_accum.sv
// Bench for arith_accum: three instances (default, ACC_W=16, N_SAMPLES=1)
// share one stimulus stream and are compared each cycle against a reference
// model of clamped totals, plus directed burst/saturation/reset sequences.
module tb_arith_accum;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [8:0]  sum_in = '0;
  logic [15:0] prod_in = '0;

  logic [2:0]  ir, ov, bz, st;
  logic [7:0]  cn [3];
  logic [23:0] ap0, as0, ap2, as2;
  logic [15:0] ap1, as1;

  arith_accum #(.N_SAMPLES(4), .ACC_W(24)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(ir[0]),
    .sum_in(sum_in), .prod_in(prod_in), .out_valid(ov[0]), .out_ready(out_ready),
    .acc_prod(ap0), .acc_sum(as0), .count(cn[0]), .sat(st[0]), .busy(bz[0]));

  arith_accum #(.N_SAMPLES(4), .ACC_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(ir[1]),
    .sum_in(sum_in), .prod_in(prod_in), .out_valid(ov[1]), .out_ready(out_ready),
    .acc_prod(ap1), .acc_sum(as1), .count(cn[1]), .sat(st[1]), .busy(bz[1]));

  arith_accum #(.N_SAMPLES(1), .ACC_W(24)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(ir[2]),
    .sum_in(sum_in), .prod_in(prod_in), .out_valid(ov[2]), .out_ready(out_ready),
    .acc_prod(ap2), .acc_sum(as2), .count(cn[2]), .sat(st[2]), .busy(bz[2]));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // ph: 0 waiting for start, 1 collecting, 2 holding results
  typedef struct {
    int     ph;
    int     cnt;
    longint ps;
    longint ss;
    bit     st;
  } mst_t;

  mst_t m [3];

  function automatic int n_of(input int k);
    return (k == 2) ? 1 : 4;
  endfunction

  function automatic longint mx_of(input int k);
    return (k == 1) ? 64'd65535 : 64'd16777215;
  endfunction

  function automatic longint ap_of(input int k);
    case (k)
      0:       return longint'(ap0);
      1:       return longint'(ap1);
      default: return longint'(ap2);
    endcase
  endfunction

  function automatic longint as_of(input int k);
    case (k)
      0:       return longint'(as0);
      1:       return longint'(as1);
      default: return longint'(as2);
    endcase
  endfunction

  function automatic mst_t step(input mst_t cur, input int n, input longint mx);
    mst_t   r;
    longint t;
    r = cur;
    case (cur.ph)
      0: if (start) begin
        r.ph = 1; r.cnt = 0; r.ps = 0; r.ss = 0; r.st = 1'b0;
      end
      1: if (in_valid) begin
        t = cur.ps + longint'(prod_in);
        if (t > mx) begin t = mx; r.st = 1'b1; end
        r.ps = t;
        t = cur.ss + longint'(sum_in);
        if (t > mx) begin t = mx; r.st = 1'b1; end
        r.ss = t;
        r.cnt = cur.cnt + 1;
        if (r.cnt == n) r.ph = 2;
      end
      default: if (out_ready) r.ph = 0;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) m[k] <= '{default: 0};
      else        m[k] <= step(m[k], n_of(k), mx_of(k));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("u%0d.in_ready", k),  ir[k], m[k].ph == 1);
        chk($sformatf("u%0d.out_valid", k), ov[k], m[k].ph == 2);
        chk($sformatf("u%0d.busy", k),      bz[k], m[k].ph != 0);
        chk($sformatf("u%0d.count", k),     cn[k], m[k].cnt);
        chk($sformatf("u%0d.sat", k),       st[k], m[k].st);
        chk($sformatf("u%0d.acc_prod", k),  ap_of(k), m[k].ps);
        chk($sformatf("u%0d.acc_sum", k),   as_of(k), m[k].ss);
      end
    end
  end

  // ---------------- directed tables ----------------
  typedef struct {
    logic [8:0]  s;
    logic [15:0] p;
  } smp_t;

  typedef struct {
    int     stall;
    int     lat;
    longint e_prod;
    longint e_sum;
    int     e_cnt;
  } burst_t;

  smp_t   smp [4];
  burst_t bursts [2];

  task automatic run_burst(input int stall, output int lat);
    int cyc;
    lat = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        for (int s = 0; s < stall; s++) begin
          in_valid = 1'b0;
          @(negedge clk);
          cyc++;
          if (ov[0] && lat < 0) lat = cyc;
        end
      end
      in_valid = 1'b1;
      sum_in   = smp[i].s;
      prod_in  = smp[i].p;
      @(negedge clk);
      cyc++;
      if (ov[0] && lat < 0) lat = cyc;
    end
    in_valid = 1'b0;
    for (int j = 0; j < 20 && lat < 0; j++) begin
      @(negedge clk);
      cyc++;
      if (ov[0]) lat = cyc;
    end
  endtask

  longint sat_exp [4];
  bit     sat_fl  [4];

  initial begin
    int lat;
    smp[0] = '{9'd30,  16'd200};
    smp[1] = '{9'd70,  16'd1200};
    smp[2] = '{9'd130, 16'd4000};
    smp[3] = '{9'd230, 16'd11200};
    bursts[0] = '{0, 5,  16600, 460, 4};
    bursts[1] = '{2, 11, 16600, 460, 4};
    sat_exp = '{65025, 65535, 65535, 65535};
    sat_fl  = '{1'b0, 1'b1, 1'b1, 1'b1};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst.in_ready",  ir[0], 0);
    chk("rst.out_valid", ov[0], 0);
    chk("rst.busy",      bz[0], 0);
    chk("rst.sat",       st[0], 0);
    chk("rst.count",     cn[0], 0);
    chk("rst.acc_prod",  ap0, 0);
    chk("rst.acc_sum",   as0, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // nominal and stalled bursts
    for (int b = 0; b < 2; b++) begin
      run_burst(bursts[b].stall, lat);
      chk($sformatf("burst%0d.latency", b),  lat, bursts[b].lat);
      chk($sformatf("burst%0d.acc_prod", b), ap0, bursts[b].e_prod);
      chk($sformatf("burst%0d.acc_sum", b),  as0, bursts[b].e_sum);
      chk($sformatf("burst%0d.count", b),    cn[0], bursts[b].e_cnt);
      chk($sformatf("burst%0d.sat", b),      st[0], 0);
      if (b == 0) begin
        // output backpressure with stray in_valid pulses
        for (int i = 0; i < 10; i++) begin
          in_valid = i[0];
          prod_in  = 16'd999;
          sum_in   = 9'd99;
          @(negedge clk);
          chk("bp.out_valid", ov[0], 1);
          chk("bp.acc_prod",  ap0, 16600);
          chk("bp.acc_sum",   as0, 460);
          chk("bp.count",     cn[0], 4);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("hand.busy",         bz[0], 0);
        chk("hand.out_valid",    ov[0], 0);
        chk("persist.acc_prod",  ap0, 16600);
        chk("persist.count",     cn[0], 4);
      end else begin
        // start coinciding with the handoff is dropped
        out_ready = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        chk("hand_start.busy0", bz[0], 0);
        @(negedge clk);
        chk("hand_start.busy1", bz[0], 0);
      end
    end

    // saturation on the 16-bit instance
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      prod_in  = 16'd65025;
      sum_in   = 9'd0;
      @(negedge clk);
      chk($sformatf("sat%0d.acc_prod", i), ap1, sat_exp[i]);
      chk($sformatf("sat%0d.sat", i),      st[1], sat_fl[i]);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("sat.held_after_handoff", st[1], 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("sat.cleared", st[1], 0);
    chk("sat.prod_cleared", ap1, 0);

    // start ignored while collecting
    start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("start_ign.count", cn[0], 0);
    chk("start_ign.busy",  bz[0], 1);

    // reset mid-burst after two samples, between clock edges
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      prod_in  = 16'd7;
      sum_in   = 9'd5;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("mid.count_before", cn[0], 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid.in_ready", ir[0], 0);
    chk("mid.busy",     bz[0], 0);
    chk("mid.count",    cn[0], 0);
    chk("mid.acc_prod", ap0, 0);
    chk("mid.acc_sum",  as0, 0);
    chk("mid.u2_busy",  bz[2], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid.no_resume", bz[0], 0);

    // single-sample burst on the N_SAMPLES=1 instance
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("n1.pre_out_valid", ov[2], 0);
    in_valid = 1'b1;
    prod_in  = 16'd65535;
    sum_in   = 9'd510;
    @(negedge clk);
    in_valid = 1'b0;
    chk("n1.out_valid", ov[2], 1);
    chk("n1.acc_prod",  ap2, 65535);
    chk("n1.acc_sum",   as2, 510);
    chk("n1.count",     cn[2], 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      start     = ($urandom_range(0, 7) == 0);
      in_valid  = $urandom_range(0, 1) == 1;
      out_ready = ($urandom_range(0, 3) == 0);
      sum_in    = 9'($urandom_range(0, 511));
      prod_in   = 16'($urandom_range(0, 65535));
      @(negedge clk);
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
